// File: rtl/pipe_datapath.sv
// ---------------------------------------------------------------------------
// pipe_datapath -- five-stage (F/D/E/M/W) RV-style integer datapath.
//
// The instruction decoder sits outside this block: it decodes InstrD and
// returns the D-stage control bits. This block holds the PC, the four
// pipeline registers, the register file, immediate generation, the ALU,
// branch resolution (in E) and the hazard unit.
//
// Build option: define PIPE_DATAPATH_FORWARD_EN to enable M/W -> E operand
// forwarding (only load-use then stalls). Without it there are no bypass
// paths and D stalls on any RAW dependence against E or M.
//
// Parameters
//   XLEN      datapath / register width (32 or 64)
//   RESET_PC  PCF value after reset
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   InstrF       instruction fetched at PCF
//   ReadDataM    data-memory read data for the instruction in M
//   RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD   decoded controls for InstrD
//   ResultSrcD   writeback select: 0 ALU, 1 memory, 2 PC+4, 3 immediate
//   ALUControlD  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu,
//                7 sll, 8 srl, 9 sra (others behave as add)
//   ImmSrcD      0 I, 1 S, 2 B, 3 J, 4 U
//   PCF          fetch address
//   InstrD       instruction in decode
//   ALUResultM   data-memory address
//   WriteDataM   store data
//   MemWriteM    store strobe
// ---------------------------------------------------------------------------
module pipe_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [3:0]      ALUControlD,
  input  logic [2:0]      ImmSrcD,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic            MemWriteM
);

  localparam int unsigned SHW       = $clog2(XLEN);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fd_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [3:0]      alu_ctrl;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus4;
  } de_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm;
  } em_t;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm;
  } mw_t;

  logic [XLEN-1:0] pc_q, pc_d;
  fd_t             fd_q, fd_d;
  de_t             de_q, de_d;
  em_t             em_q, em_d;
  mw_t             mw_q, mw_d;

  logic [XLEN-1:0] rf [0:31];

  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d;
  logic [31:0]     imm32_d;
  logic [XLEN-1:0] pc_plus4_f, pc_target_e;
  logic [XLEN-1:0] src_a_e, src_b_e, write_data_e, alu_result_e;
  logic [XLEN-1:0] result_w;
  logic            zero_e, pcsrc_e, lw_stall, stall;
  logic            unused_opcode;

  assign PCF        = pc_q;
  assign InstrD     = fd_q.instr;
  assign ALUResultM = em_q.alu_result;
  assign WriteDataM = em_q.write_data;
  assign MemWriteM  = em_q.mem_write;

  assign pc_plus4_f    = pc_q + XLEN'(4);
  assign rs1_d         = fd_q.instr[19:15];
  assign rs2_d         = fd_q.instr[24:20];
  assign rd_d          = fd_q.instr[11:7];
  assign unused_opcode = ^fd_q.instr[6:0];

  // ---------------- Decode: register file with write-through ---------------
  always_ff @(posedge clk) begin
    if (mw_q.reg_write && (mw_q.rd != '0)) begin
      rf[mw_q.rd] <= result_w;
    end
  end

  // A W-stage write to the register being read appears in the same cycle.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1_d != '0) begin
      rd1_d = (mw_q.reg_write && (mw_q.rd == rs1_d)) ? result_w : rf[rs1_d];
    end
    if (rs2_d != '0) begin
      rd2_d = (mw_q.reg_write && (mw_q.rd == rs2_d)) ? result_w : rf[rs2_d];
    end
  end

  // Immediates are assembled as 32 bits, then sign-extended to XLEN.
  always_comb begin
    imm32_d = '0;
    case (ImmSrcD)
      3'd0: imm32_d = {{20{fd_q.instr[31]}}, fd_q.instr[31:20]};
      3'd1: imm32_d = {{20{fd_q.instr[31]}}, fd_q.instr[31:25], fd_q.instr[11:7]};
      3'd2: imm32_d = {{20{fd_q.instr[31]}}, fd_q.instr[7], fd_q.instr[30:25],
                       fd_q.instr[11:8], 1'b0};
      3'd3: imm32_d = {{12{fd_q.instr[31]}}, fd_q.instr[19:12], fd_q.instr[20],
                       fd_q.instr[30:21], 1'b0};
      3'd4: imm32_d = {fd_q.instr[31:12], 12'b0};
      default: imm32_d = '0;
    endcase
    imm_ext_d = XLEN'($signed(imm32_d));
  end

  // ---------------- Hazard unit and operand selection -----------------------
  assign lw_stall = (de_q.result_src == 2'd1) && (de_q.rd != '0) &&
                    ((de_q.rd == rs1_d) || (de_q.rd == rs2_d));

`ifdef PIPE_DATAPATH_FORWARD_EN
  logic [XLEN-1:0] fwd_m;

  // The M-side bypass value is ALUResultM, except for PC+4 / immediate
  // writebacks whose result does not come out of the ALU.
  always_comb begin
    case (em_q.result_src)
      2'd2:    fwd_m = em_q.pc_plus4;
      2'd3:    fwd_m = em_q.imm;
      default: fwd_m = em_q.alu_result;
    endcase
  end

  always_comb begin
    src_a_e      = de_q.rd1;
    write_data_e = de_q.rd2;
    if (em_q.reg_write && (em_q.rd != '0) && (em_q.rd == de_q.rs1)) begin
      src_a_e = fwd_m;
    end else if (mw_q.reg_write && (mw_q.rd != '0) && (mw_q.rd == de_q.rs1)) begin
      src_a_e = result_w;
    end
    if (em_q.reg_write && (em_q.rd != '0) && (em_q.rd == de_q.rs2)) begin
      write_data_e = fwd_m;
    end else if (mw_q.reg_write && (mw_q.rd != '0) && (mw_q.rd == de_q.rs2)) begin
      write_data_e = result_w;
    end
  end

  assign stall = lw_stall;
`else
  always_comb begin
    src_a_e      = de_q.rd1;
    write_data_e = de_q.rd2;
  end

  assign stall = lw_stall ||
    ((rs1_d != '0) && ((de_q.reg_write && (de_q.rd == rs1_d)) ||
                       (em_q.reg_write && (em_q.rd == rs1_d)))) ||
    ((rs2_d != '0) && ((de_q.reg_write && (de_q.rd == rs2_d)) ||
                       (em_q.reg_write && (em_q.rd == rs2_d))));
`endif

  // ---------------- Execute -------------------------------------------------
  assign src_b_e = de_q.alu_src ? de_q.imm : write_data_e;

  always_comb begin
    alu_result_e = '0;
    case (alu_op_e'(de_q.alu_ctrl))
      ALU_SUB:  alu_result_e = src_a_e - src_b_e;
      ALU_AND:  alu_result_e = src_a_e & src_b_e;
      ALU_OR:   alu_result_e = src_a_e | src_b_e;
      ALU_XOR:  alu_result_e = src_a_e ^ src_b_e;
      ALU_SLT:  alu_result_e = XLEN'($signed(src_a_e) < $signed(src_b_e));
      ALU_SLTU: alu_result_e = XLEN'(src_a_e < src_b_e);
      ALU_SLL:  alu_result_e = src_a_e << src_b_e[SHW-1:0];
      ALU_SRL:  alu_result_e = src_a_e >> src_b_e[SHW-1:0];
      ALU_SRA:  alu_result_e = $unsigned($signed(src_a_e) >>> src_b_e[SHW-1:0]);
      default:  alu_result_e = src_a_e + src_b_e;
    endcase
  end

  assign zero_e      = (alu_result_e == '0);
  assign pcsrc_e     = (de_q.branch && zero_e) || de_q.jump;
  assign pc_target_e = de_q.pc + de_q.imm;

  // ---------------- Writeback -----------------------------------------------
  always_comb begin
    case (mw_q.result_src)
      2'd1:    result_w = mw_q.read_data;
      2'd2:    result_w = mw_q.pc_plus4;
      2'd3:    result_w = mw_q.imm;
      default: result_w = mw_q.alu_result;
    endcase
  end

  // ---------------- Next-state: a taken branch/jump outranks a stall -------
  always_comb begin
    pc_d = pc_q;
    fd_d = fd_q;
    if (pcsrc_e) begin
      pc_d = pc_target_e;
      fd_d = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
    end else if (!stall) begin
      pc_d = pc_plus4_f;
      fd_d = '{instr: InstrF, pc: pc_q, pc_plus4: pc_plus4_f};
    end

    de_d = '0;
    if (!pcsrc_e && !stall) begin
      de_d.reg_write  = RegWriteD;
      de_d.result_src = ResultSrcD;
      de_d.mem_write  = MemWriteD;
      de_d.jump       = JumpD;
      de_d.branch     = BranchD;
      de_d.alu_ctrl   = ALUControlD;
      de_d.alu_src    = ALUSrcD;
      de_d.rd1        = rd1_d;
      de_d.rd2        = rd2_d;
      de_d.pc         = fd_q.pc;
      de_d.rs1        = rs1_d;
      de_d.rs2        = rs2_d;
      de_d.rd         = rd_d;
      de_d.imm        = imm_ext_d;
      de_d.pc_plus4   = fd_q.pc_plus4;
    end

    em_d.reg_write  = de_q.reg_write;
    em_d.result_src = de_q.result_src;
    em_d.mem_write  = de_q.mem_write;
    em_d.alu_result = alu_result_e;
    em_d.write_data = write_data_e;
    em_d.rd         = de_q.rd;
    em_d.pc_plus4   = de_q.pc_plus4;
    em_d.imm        = de_q.imm;

    mw_d.reg_write  = em_q.reg_write;
    mw_d.result_src = em_q.result_src;
    mw_d.alu_result = em_q.alu_result;
    mw_d.read_data  = ReadDataM;
    mw_d.rd         = em_q.rd;
    mw_d.pc_plus4   = em_q.pc_plus4;
    mw_d.imm        = em_q.imm;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      fd_q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else begin
      pc_q <= pc_d;
      fd_q <= fd_d;
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

endmodule
